// File: rtl/multi_dispatch_queue_pkg.sv
// Shared types for the multi-lane dispatch queue: ROB index, entry metadata,
// and the ROB age comparison. FETCH_WIDTH / PREG_WIDTH fall back to defaults.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef PREG_WIDTH
`define PREG_WIDTH 6
`endif

package multi_dispatch_queue_pkg;
  localparam int PREG_W    = `PREG_WIDTH;
  localparam int ROB_IDX_W = 5;
  localparam int DQ_DATA_W = 1;

  typedef struct packed {
    logic                 dir;
    logic [ROB_IDX_W-1:0] idx;
  } rob_idx_t;

  typedef struct packed {
    logic [PREG_W-1:0] rs1;
    logic [PREG_W-1:0] rs2;
    rob_idx_t          rob_idx;
  } dq_meta_t;

  // dir flips each time the ROB pointer wraps, inverting the idx order
  function automatic logic rob_older(input rob_idx_t a, input rob_idx_t b);
    return (a.dir == b.dir) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction
endpackage

// File: rtl/multi_dispatch_queue_survivor_count.sv
// Counts the entries, from head onward, that are strictly older than
// the redirect point; the queue is in program order so they form a prefix.
module dq_survivor_count
  import multi_dispatch_queue_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] head,
  input  logic [ADDR_WIDTH:0]   num,
  input  rob_idx_t              rob_idx [DEPTH],
  input  rob_idx_t              redirect_idx,
  output logic [ADDR_WIDTH:0]   surv
);
  logic [DEPTH-1:0] older;
  logic             run;

  always_comb begin
    older = '0;
    for (int i = 0; i < DEPTH; i++) begin
      older[i] = ((ADDR_WIDTH+1)'(i) < num) &&
                 rob_older(rob_idx[head + ADDR_WIDTH'(i)], redirect_idx);
    end
  end

  always_comb begin
    surv = '0;
    run  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      run  = run & older[i];
      surv = surv + (ADDR_WIDTH+1)'(run);
    end
  end
endmodule

// File: rtl/multi_dispatch_queue.sv
// In-order dispatch buffer: multi-lane compacting enqueue, prefix dequeue,
// single-cycle redirect squash. Perf counters under DISPATCH_QUEUE_PERF_EN.
module multi_dispatch_queue
  import multi_dispatch_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DQ_DATA_W,
  parameter int DEPTH      = 16,
  parameter int IN_WIDTH   = `FETCH_WIDTH,
  parameter int OUT_WIDTH  = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IN_WIDTH-1:0]                  in_valid,
  input  logic [IN_WIDTH-1:0][PREG_W-1:0]      in_rs1,
  input  logic [IN_WIDTH-1:0][PREG_W-1:0]      in_rs2,
  input  rob_idx_t [IN_WIDTH-1:0]              in_robIdx,
  input  logic [IN_WIDTH-1:0][DATA_WIDTH-1:0]  in_data,
  input  logic                                 in_stall,
  output logic                                 full,
  output logic [OUT_WIDTH-1:0]                 out_valid,
  output logic [OUT_WIDTH-1:0][PREG_W-1:0]     out_rs1,
  output logic [OUT_WIDTH-1:0][PREG_W-1:0]     out_rs2,
  output rob_idx_t [OUT_WIDTH-1:0]             out_robIdx,
  output logic [OUT_WIDTH-1:0][DATA_WIDTH-1:0] out_data,
  input  logic [$clog2(OUT_WIDTH):0]           out_accept,
  input  logic                                 redirect,
  input  rob_idx_t                             redirectIdx,
  output logic [ADDR_WIDTH:0]                  count,
  output logic [31:0]                          perf_full_cycles,
  output logic [31:0]                          perf_enq_total
);
  localparam int CW = ADDR_WIDTH + 1;

  typedef struct packed {
    dq_meta_t              meta;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                mem     [DEPTH];
  rob_idx_t              rob_arr [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_idx  [IN_WIDTH];
  logic [ADDR_WIDTH-1:0] head, tail, off;
  logic [CW-1:0]         num, surv, in_cnt, enq, acc, vcnt;
  logic                  enq_fire;

  always_comb begin
    in_cnt = '0;
    off    = '0;
    for (int j = 0; j < IN_WIDTH; j++) begin
      wr_idx[j] = tail + off;
      off       = off + ADDR_WIDTH'(in_valid[j]);
      in_cnt    = in_cnt + CW'(in_valid[j]);
    end
  end

  assign full     = ({1'b0, num} + {1'b0, in_cnt}) > (CW+1)'(DEPTH);
  assign enq_fire = !in_stall && !redirect && !full;
  assign enq      = enq_fire ? in_cnt : '0;
  assign count    = num;

  always_comb begin
    for (int d = 0; d < DEPTH; d++) rob_arr[d] = mem[d].meta.rob_idx;
  end

  dq_survivor_count #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_surv (
    .head         (head),
    .num          (num),
    .rob_idx      (rob_arr),
    .redirect_idx (redirectIdx),
    .surv         (surv)
  );

  // survivors are a prefix, so i < surv equals the per-entry age gate
  always_comb begin
    vcnt = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      out_valid[i]  = redirect ? (CW'(i) < surv) : (CW'(i) < num);
      out_rs1[i]    = mem[head + ADDR_WIDTH'(i)].meta.rs1;
      out_rs2[i]    = mem[head + ADDR_WIDTH'(i)].meta.rs2;
      out_robIdx[i] = mem[head + ADDR_WIDTH'(i)].meta.rob_idx;
      out_data[i]   = mem[head + ADDR_WIDTH'(i)].data;
      vcnt          = vcnt + CW'(out_valid[i]);
    end
  end

  assign acc = (CW'(out_accept) > vcnt) ? vcnt : CW'(out_accept);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      num  <= '0;
      for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
    end else begin
      head <= head + acc[ADDR_WIDTH-1:0];
      if (redirect) begin
        num  <= surv - acc;
        tail <= head + surv[ADDR_WIDTH-1:0];
      end else begin
        num  <= num + enq - acc;
        tail <= tail + enq[ADDR_WIDTH-1:0];
        if (enq_fire) begin
          for (int j = 0; j < IN_WIDTH; j++) begin
            if (in_valid[j]) begin
              mem[wr_idx[j]] <= '{
                meta: '{rs1: in_rs1[j], rs2: in_rs2[j],
                        rob_idx: in_robIdx[j]},
                data: in_data[j]};
            end
          end
        end
      end
    end
  end

`ifdef DISPATCH_QUEUE_PERF_EN
  logic [31:0] full_q, enq_q;
  logic [32:0] enq_sum;

  assign enq_sum = {1'b0, enq_q} + 33'(enq);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= '0;
      enq_q  <= '0;
    end else begin
      if (full && |in_valid && full_q != '1) full_q <= full_q + 32'd1;
      enq_q <= enq_sum[32] ? '1 : enq_sum[31:0];
    end
  end

  assign perf_full_cycles = full_q;
  assign perf_enq_total   = enq_q;
`else
  assign perf_full_cycles = '0;
  assign perf_enq_total   = '0;
`endif

`ifndef SYNTHESIS
  a_accept_le_valid: assert property (
    @(posedge clk) disable iff (!rst) CW'(out_accept) <= vcnt);
`endif
endmodule

// File: doc/multi_dispatch_queue.md
# multi_dispatch_queue

Parametrised in-order dispatch buffer between rename and the issue queues. It accepts up to IN_WIDTH renamed micro-ops per cycle and presents the oldest OUT_WIDTH entries to an issue queue. The issue queue may accept any prefix of them, not only all or none. On a backend redirect it squashes every entry younger than the redirect point in a single cycle, while the older entries keep issuing that same cycle.

## Interface
Parameters:
- DATA_WIDTH, 1: payload bits per entry.
- DEPTH, 16: number of entries; power of two, at least IN_WIDTH and at least OUT_WIDTH.
- IN_WIDTH, `FETCH_WIDTH: enqueue lanes.
- OUT_WIDTH, 4: dequeue slots.
- ADDR_WIDTH, $clog2(DEPTH): pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  IN_WIDTH  per-lane enqueue request.
- in_rs1, in_rs2  in  IN_WIDTH×`PREG_WIDTH  physical sources.
- in_robIdx  in  IN_WIDTH×$bits(RobIdx)  ROB index ({dir, idx}).
- in_data  in  IN_WIDTH×DATA_WIDTH  payload.
- in_stall  in  1  global dispatch stall; blocks the whole enqueue group.
- full  out  1  num + popcount(in_valid) > DEPTH.
- out_valid  out  OUT_WIDTH  slot i holds entry head+i.
- out_rs1, out_rs2, out_robIdx, out_data  out  per slot  contents of entry head+i.
- out_accept  in  $clog2(OUT_WIDTH)+1  number of slots taken this cycle, counted from slot 0.
- redirect  in  1  squash request.
- redirectIdx  in  $bits(RobIdx)  redirect point.
- count  out  ADDR_WIDTH+1  current occupancy num.
- perf_full_cycles, perf_enq_total  out  32 each  statistics counters; see Configuration.

## Operation
- State:
  - head and tail, ADDR_WIDTH bits, wrap modulo DEPTH.
  - num, ADDR_WIDTH+1 bits.
  - entry array of {rs1, rs2, robIdx, data}.
- Enqueue:
  - Fires when in_stall=0, redirect=0 and full=0.
  - Valid lanes are compacted in lane order: lane j writes tail + (number of valid lanes below j).
  - Invalid lanes consume no slot.
- Full/stall gating: when full=1 or in_stall=1, nothing is written. The upstream stage is responsible for holding the group.
- Output valid: out_valid[i] = (num > i) and not (redirect and entry head+i is not older than redirectIdx).
- Dequeue:
  - head advances by out_accept.
  - out_accept must not exceed popcount(out_valid). Larger values are a protocol error: a simulation assertion fires and the RTL clamps to popcount(out_valid).
- Age rule: a is older than b iff (a.dir == b.dir) ? a.idx < b.idx : a.idx > b.idx. An entry equal to redirectIdx is squashed.
- Redirect:
  - S = count of consecutive surviving entries from head. Survivors form a prefix because the queue is kept in program order.
  - Next state: head += out_accept, num = S − out_accept, tail = old head + S.
  - Enqueue is ignored during a redirect cycle.
- Normal update: num_next = num + enq − out_accept; tail += enq.

## Timing
- Reset values (rst low): head=tail=num=0; entries zeroed; out_valid=0; count=0; perf counters 0. Because full is combinational, full=0 whenever num=0 and popcount(in_valid) ≤ DEPTH.
- Enqueue to out_valid: 1 cycle. Data written at edge N is visible in cycle N+1.
- out_accept to head update: same edge. The next-cycle outputs show the shifted window.
- full, out_valid, out_* and count are combinational from registered state and current inputs. There is no input-to-output path except redirect and in_valid→full.
- full does not credit same-cycle dequeue (conservative).
- Wrap-around: the read index head+i and the write index are taken modulo DEPTH. Entries spanning the DEPTH−1→0 boundary behave identically to non-wrapping entries.
- Simultaneous redirect and accept: the accept is honoured for surviving slots only, which is guaranteed by the out_valid gating.
- Reset asserted mid-operation: all state clears asynchronously. Outputs return to reset values before the next edge.

## Configuration
- DISPATCH_QUEUE_PERF_EN defined:
  - perf_full_cycles increments every cycle full=1 with any in_valid set.
  - perf_enq_total adds the enqueued count each cycle.
  - Both counters saturate at 2^32−1.
- Undefined: counter flops are not instantiated and both ports are driven to constant 0.

## Structure
- Shared package: RobIdx typedef, an age-compare function implementing the Age rule, and the DispatchQueue entry struct parameterised by DATA_WIDTH (via parameterised localparam widths).
- One sub-module, dq_survivor_count. Inputs: head, num, the robIdx array, redirectIdx. Output: S.
- dq_survivor_count does a per-entry older compare in rotated order, then counts leading ones.

## Test plan
- Fill: DEPTH=8, IN_WIDTH=4, in_valid=1011 for 2 cycles → count 3 then 6, entries in lane order. Third group 0111 → full=1, count stays 6.
- Partial dequeue: 6 entries, out_accept=3 → head=3, count=3, slot 0 now shows the 4th-enqueued robIdx.
- Wrap: head=6, enqueue 4 → entries at 6,7,0,1. Dequeue across the boundary returns program order.
- Redirect: robIdx 10..15 queued, redirectIdx=13, out_accept=1 → out_valid=111000 during the cycle. Next cycle count=2, tail=head+2.
- Redirect with dir wrap: entries {dir=0,idx 30,31},{dir=1,idx 0,1}, redirectIdx={1,0} → 2 survivors. Enqueue in the same cycle is dropped.
- Stall/reset: in_stall=1 with valid lanes → no write. rst low mid-fill → count=0, out_valid=0 immediately.
